rtc_time_core: RTL and testbench
================================

Name: rtc_time_core

Overview:
- Parametrised time-of-day core: prescaler turns clk into a 1 s tick and drives cascaded seconds/minutes/hours counters.
- Adds the following over the fixed 24 h counter:
  - configurable tick period and hour modulus;
  - run/pause;
  - synchronous time load with range checking;
  - per-field increment for front-panel setting;
  - minute-resolution alarm;
  - status pulses.
- Sits between the board clock and the display/segment driver. Packed output stays format-compatible with the existing display path (17 bits at defaults).

Parameters:
- TICK_CYCLES, 50_000_000, clk cycles per second tick (>=2).
- HOURS, 24, hour modulus (2..32). Localparam H_W = clog2(HOURS), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = timekeeping advances; 0 = prescaler and time hold.
- set_en  in  1  one-cycle load strobe for set_h/set_m/set_s.
- set_h  in  H_W  load hour.
- set_m  in  6  load minute.
- set_s  in  6  load second.
- inc_h  in  1  one-cycle: hour +1 mod HOURS, no carry.
- inc_m  in  1  one-cycle: minute +1 mod 60, no carry.
- alarm_set  in  1  one-cycle: capture alarm_h/alarm_m/alarm_en_in.
- alarm_en_in  in  1  alarm enable value.
- alarm_h  in  H_W  alarm hour.
- alarm_m  in  6  alarm minute.
- dout  out  H_W+12  {hour, minute, second}, binary.
- hour12  out  4  1..12 display hour (HOURS=24 only, else 0).
- pm  out  1  hour>=12 (HOURS=24 only, else 0).
- sec_tick  out  1  pulse: time advanced by tick this cycle.
- day_wrap  out  1  pulse: HOURS-1:59:59 -> 0:00:00.
- set_err  out  1  pulse: set_en rejected.
- alarm_hit  out  1  pulse: alarm match.

Behaviour:
- Reset (async, rst_n=0) clears everything to 0:
  - prescaler, hour/min/sec, dout;
  - alarm regs (enable=0);
  - all pulses 0; hour12=12 (hour 0); pm=0.
- Prescaler:
  - When run=1: counts 0..TICK_CYCLES-1, wraps to 0.
  - tick = run && prescaler==TICK_CYCLES-1.
  - When run=0: prescaler and time hold.
- Priority per cycle: set_en > (inc_h | inc_m) > tick.
  - A tick coinciding with set_en or an inc is discarded; the prescaler still wraps.
- set_en:
  - Accepted only if set_h<HOURS, set_m<60 and set_s<60.
  - If accepted: time loads on the next edge and the prescaler clears to 0, so the next tick comes TICK_CYCLES cycles later when run=1.
  - If any field is out of range: no change, prescaler untouched, set_err=1 for one cycle.
  - set_en is honoured regardless of run.
- inc_h and inc_m:
  - Both may assert in the same cycle; both apply.
  - Seconds and prescaler are unaffected.
  - Honoured regardless of run.
- tick updates, applied at the next edge:
  - sec +1; at 59 it wraps to 0 and carries to min.
  - min at 59 wraps to 0 and carries to hour.
  - hour at HOURS-1 wraps to 0.
- Pulse timing:
  - sec_tick=1 in the cycle the new value first appears on dout (registered, same edge as the update).
  - day_wrap=1 in that same cycle when the result is all-zero from a full wrap.
- Alarm:
  - alarm_set captures the enable, hour and minute at the next edge. No range check; an out-of-range alarm never matches.
  - alarm_hit=1 for one cycle, the cycle after dout first shows alarm_h:alarm_m:00 as a result of a tick, when enable=1.
  - Reaching the alarm time through set_en or inc does not fire the alarm.
  - alarm_set in the same cycle as a matching update: the match uses the old alarm regs.
- hour12/pm are combinational from the hour register:
  - hour12 = 12 when hour%12==0, else hour%12.
  - pm = hour>=12.
- Reset mid-operation: async clear takes effect immediately. Pending pulses are lost and the alarm is disarmed.
- All outputs except hour12/pm are registered.

Test Plan (TICK_CYCLES=4, HOURS=24 unless noted):
- Reset, run=1 for 4*60 cycles -> sec_tick every 4th cycle; dout={0,1,0} after 240 cycles; no day_wrap.
- set_en with 23:59:58, run=1 -> two ticks later dout=0; day_wrap=1 coincident with second sec_tick; pm 1->0; hour12 11->12.
- set_en with 24:00:00, then 12:60:00 -> set_err pulse each; dout unchanged; prescaler phase unchanged.
- Alarm 07:30 enabled, set 07:29:59, run -> alarm_hit exactly one cycle after dout=07:30:00; set 07:30:00 directly -> no alarm_hit.
- run=0 with inc_m at 10:59:30 -> 10:00:30 (no hour carry); inc_h+inc_m same cycle at 23:59 -> 00:00; prescaler frozen.
- inc_m coincident with tick at 00:00:05 -> 00:01:05 (tick lost); rst_n pulsed mid-count -> all outputs 0 immediately.
- HOURS=12: set 11:59:59, tick -> 0:00:00 with day_wrap; hour12=0, pm=0.

Source files
------------

// File: rtl/rtc_time_core.sv
// rtc_time_core: time-of-day core. A prescaler divides clk down to a one
// second tick that advances cascaded seconds/minutes/hours counters. Adds
// run/pause, range-checked time load, per-field front-panel increment, a
// minute-resolution alarm and single-cycle status pulses.
//
// Per-cycle priority: set_en > (inc_h | inc_m) > tick. A tick that loses
// to set_en or an increment is dropped; the prescaler still wraps unless an
// accepted load clears it.
module rtc_time_core #(
    parameter int  TICK_CYCLES = 50_000_000,
    parameter int  HOURS       = 24,
    localparam int H_W         = (HOURS <= 2) ? 1 : $clog2(HOURS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             set_en,
    input  logic [H_W-1:0]   set_h,
    input  logic [5:0]       set_m,
    input  logic [5:0]       set_s,
    input  logic             inc_h,
    input  logic             inc_m,
    input  logic             alarm_set,
    input  logic             alarm_en_in,
    input  logic [H_W-1:0]   alarm_h,
    input  logic [5:0]       alarm_m,
    output logic [H_W+11:0]  dout,
    output logic [3:0]       hour12,
    output logic             pm,
    output logic             sec_tick,
    output logic             day_wrap,
    output logic             set_err,
    output logic             alarm_hit
);

    localparam int               PW      = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]    P_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [H_W-1:0]   H_LAST  = H_W'(HOURS - 1);
    localparam logic [H_W:0]     HOURS_C = (H_W + 1)'(HOURS);

    logic [PW-1:0]  presc_q, presc_d;
    logic [H_W-1:0] h_q, h_d;
    logic [5:0]     m_q, m_d;
    logic [5:0]     s_q, s_d;
    logic           sec_tick_q, sec_tick_d;
    logic           day_wrap_q, day_wrap_d;
    logic           set_err_q, set_err_d;
    logic           match_q, match_d;
    logic           alarm_hit_q;
    logic           alarm_en_q;
    logic [H_W-1:0] alarm_h_q;
    logic [5:0]     alarm_m_q;

    logic tick;
    logic set_ok;

    assign tick   = run && (presc_q == P_LAST);
    assign set_ok = ({1'b0, set_h} < HOURS_C) && (set_m < 6'd60) && (set_s < 6'd60);

    // Next-state for prescaler, time counters and status pulses.
    always_comb begin
        presc_d    = presc_q;
        h_d        = h_q;
        m_d        = m_q;
        s_d        = s_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        set_err_d  = 1'b0;
        match_d    = 1'b0;

        if (run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (set_en) begin
            if (set_ok) begin
                h_d     = set_h;
                m_d     = set_m;
                s_d     = set_s;
                presc_d = '0;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (inc_h || inc_m) begin
            if (inc_h) begin
                h_d = (h_q == H_LAST) ? '0 : h_q + H_W'(1);
            end
            if (inc_m) begin
                m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
            end
        end else if (tick) begin
            sec_tick_d = 1'b1;
            if (s_q == 6'd59) begin
                s_d = 6'd0;
                if (m_q == 6'd59) begin
                    m_d = 6'd0;
                    h_d = (h_q == H_LAST) ? '0 : h_q + H_W'(1);
                end else begin
                    m_d = m_q + 6'd1;
                end
            end else begin
                s_d = s_q + 6'd1;
            end
            day_wrap_d = (s_q == 6'd59) && (m_q == 6'd59) && (h_q == H_LAST);
            // Compared against the alarm registers as they stand this cycle,
            // so an alarm_set landing on the same edge does not affect it.
            match_d = alarm_en_q && (h_d == alarm_h_q) && (m_d == alarm_m_q) && (s_d == 6'd0);
        end
    end

    // Time, prescaler and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            h_q         <= '0;
            m_q         <= '0;
            s_q         <= '0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            set_err_q   <= 1'b0;
            match_q     <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            h_q         <= h_d;
            m_q         <= m_d;
            s_q         <= s_d;
            sec_tick_q  <= sec_tick_d;
            day_wrap_q  <= day_wrap_d;
            set_err_q   <= set_err_d;
            match_q     <= match_d;
            alarm_hit_q <= match_q;
        end
    end

    // Alarm configuration capture; reset disarms the alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_en_q <= 1'b0;
            alarm_h_q  <= '0;
            alarm_m_q  <= '0;
        end else if (alarm_set) begin
            alarm_en_q <= alarm_en_in;
            alarm_h_q  <= alarm_h;
            alarm_m_q  <= alarm_m;
        end
    end

    assign dout      = {h_q, m_q, s_q};
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign set_err   = set_err_q;
    assign alarm_hit = alarm_hit_q;

    generate
        if (HOURS == 24) begin : g_h12
            logic [H_W-1:0] h_mod;
            // 12-hour display view of the hour register.
            always_comb begin
                h_mod  = (h_q >= H_W'(12)) ? h_q - H_W'(12) : h_q;
                hour12 = (h_mod == '0) ? 4'd12 : 4'(h_mod);
                pm     = (h_q >= H_W'(12));
            end
        end else begin : g_no_h12
            assign hour12 = 4'd0;
            assign pm     = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rtc_time_core.sv
// tb_rtc_time_core: directed bench for rtc_time_core with TICK_CYCLES=4.
// A 24 h instance carries most scenarios; a 12 h instance covers the
// alternate hour modulus.
module tb_rtc_time_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 24 h instance signals
    logic        rst_n, run, set_en, inc_h, inc_m, alarm_set, alarm_en_in;
    logic [4:0]  set_h, alarm_h;
    logic [5:0]  set_m, set_s, alarm_m;
    logic [16:0] dout;
    logic [3:0]  hour12;
    logic        pm, sec_tick, day_wrap, set_err, alarm_hit;

    // 12 h instance signals
    logic        run12, set_en12;
    logic [3:0]  set_h12;
    logic [5:0]  set_m12, set_s12;
    logic [15:0] dout12;
    logic [3:0]  hour12_12;
    logic        pm12, sec_tick12, day_wrap12, set_err12, alarm_hit12;

    int checks = 0;
    int errors = 0;

    rtc_time_core #(.TICK_CYCLES(4), .HOURS(24)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .set_en(set_en), .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .inc_h(inc_h), .inc_m(inc_m),
        .alarm_set(alarm_set), .alarm_en_in(alarm_en_in),
        .alarm_h(alarm_h), .alarm_m(alarm_m),
        .dout(dout), .hour12(hour12), .pm(pm),
        .sec_tick(sec_tick), .day_wrap(day_wrap),
        .set_err(set_err), .alarm_hit(alarm_hit)
    );

    rtc_time_core #(.TICK_CYCLES(4), .HOURS(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .run(run12),
        .set_en(set_en12), .set_h(set_h12), .set_m(set_m12), .set_s(set_s12),
        .inc_h(1'b0), .inc_m(1'b0),
        .alarm_set(1'b0), .alarm_en_in(1'b0),
        .alarm_h(4'd0), .alarm_m(6'd0),
        .dout(dout12), .hour12(hour12_12), .pm(pm12),
        .sec_tick(sec_tick12), .day_wrap(day_wrap12),
        .set_err(set_err12), .alarm_hit(alarm_hit12)
    );

    // Advance one clock; return 1 time unit after the edge so outputs are settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] t24(input int h, input int m, input int s);
        logic [16:0] v;
        v = {5'(h), 6'(m), 6'(s)};
        return 32'(v);
    endfunction

    task automatic set_time(input int h, input int m, input int s);
        set_h  = 5'(h);
        set_m  = 6'(m);
        set_s  = 6'(s);
        set_en = 1'b1;
        cyc();
        set_en = 1'b0;
    endtask

    initial begin
        int tick_cnt;
        int tick_bad;
        int wrap_cnt;
        int hit_cnt;

        rst_n = 1'b0; run = 1'b0; set_en = 1'b0; inc_h = 1'b0; inc_m = 1'b0;
        alarm_set = 1'b0; alarm_en_in = 1'b0;
        set_h = '0; set_m = '0; set_s = '0; alarm_h = '0; alarm_m = '0;
        run12 = 1'b0; set_en12 = 1'b0; set_h12 = '0; set_m12 = '0; set_s12 = '0;

        // Reset state
        repeat (2) cyc();
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_hour12", 32'(hour12), 32'd12);
        check_eq("rst_pm", 32'(pm), 32'd0);
        check_eq("rst_pulses", {28'd0, sec_tick, day_wrap, set_err, alarm_hit}, 32'd0);
        check_eq("rst_hour12_h12", 32'(hour12_12), 32'd0);

        // Free run for one minute: tick on every 4th cycle
        rst_n = 1'b1;
        run   = 1'b1;
        tick_cnt = 0; tick_bad = 0; wrap_cnt = 0;
        for (int i = 0; i < 240; i++) begin
            cyc();
            if (sec_tick) tick_cnt++;
            if (sec_tick !== ((i % 4) == 3)) tick_bad++;
            if (day_wrap) wrap_cnt++;
        end
        check_eq("run_tick_cnt", 32'(tick_cnt), 32'd60);
        check_eq("run_tick_phase", 32'(tick_bad), 32'd0);
        check_eq("run_no_wrap", 32'(wrap_cnt), 32'd0);
        check_eq("run_dout_1min", 32'(dout), t24(0, 1, 0));

        // Day wrap from 23:59:58
        set_time(23, 59, 58);
        check_eq("wrap_load", 32'(dout), t24(23, 59, 58));
        check_eq("wrap_pm_before", 32'(pm), 32'd1);
        check_eq("wrap_h12_before", 32'(hour12), 32'd11);
        repeat (4) cyc();
        check_eq("wrap_first_tick", 32'(dout), t24(23, 59, 59));
        check_eq("wrap_no_early_wrap", 32'(day_wrap), 32'd0);
        repeat (4) cyc();
        check_eq("wrap_dout", 32'(dout), 32'd0);
        check_eq("wrap_sec_tick", 32'(sec_tick), 32'd1);
        check_eq("wrap_day_wrap", 32'(day_wrap), 32'd1);
        check_eq("wrap_pm_after", 32'(pm), 32'd0);
        check_eq("wrap_h12_after", 32'(hour12), 32'd12);

        // Rejected loads leave time and prescaler phase alone
        set_h = 5'd24; set_m = 6'd0; set_s = 6'd0; set_en = 1'b1;
        cyc();
        check_eq("bad_hour_err", 32'(set_err), 32'd1);
        check_eq("bad_hour_dout", 32'(dout), 32'd0);
        set_h = 5'd12; set_m = 6'd60;
        cyc();
        set_en = 1'b0;
        check_eq("bad_min_err", 32'(set_err), 32'd1);
        check_eq("bad_min_dout", 32'(dout), 32'd0);
        cyc();
        check_eq("bad_err_clear", 32'(set_err), 32'd0);
        check_eq("bad_phase_no_tick", 32'(sec_tick), 32'd0);
        cyc();
        check_eq("bad_phase_tick", 32'(sec_tick), 32'd1);
        check_eq("bad_phase_dout", 32'(dout), t24(0, 0, 1));

        // Alarm at 07:30 reached by tick
        alarm_h = 5'd7; alarm_m = 6'd30; alarm_en_in = 1'b1; alarm_set = 1'b1;
        cyc();
        alarm_set = 1'b0;
        set_time(7, 29, 59);
        repeat (3) cyc();
        check_eq("alm_not_yet", 32'(alarm_hit), 32'd0);
        cyc();
        check_eq("alm_dout", 32'(dout), t24(7, 30, 0));
        check_eq("alm_same_cycle", 32'(alarm_hit), 32'd0);
        cyc();
        check_eq("alm_hit", 32'(alarm_hit), 32'd1);
        cyc();
        check_eq("alm_one_cycle", 32'(alarm_hit), 32'd0);
        // Reaching the alarm time by loading it does not fire
        set_time(7, 30, 0);
        hit_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (alarm_hit) hit_cnt++;
            cyc();
        end
        check_eq("alm_set_no_hit", 32'(hit_cnt), 32'd0);

        // Paused increments
        run = 1'b0;
        set_time(10, 59, 30);
        inc_m = 1'b1;
        cyc();
        inc_m = 1'b0;
        check_eq("inc_m_no_carry", 32'(dout), t24(10, 0, 30));
        set_time(23, 59, 30);
        inc_h = 1'b1; inc_m = 1'b1;
        cyc();
        inc_h = 1'b0; inc_m = 1'b0;
        check_eq("inc_both", 32'(dout), t24(0, 0, 30));
        check_eq("inc_no_wrap_pulse", 32'(day_wrap), 32'd0);
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (sec_tick) tick_cnt++;
        end
        check_eq("pause_no_tick", 32'(tick_cnt), 32'd0);
        check_eq("pause_hold", 32'(dout), t24(0, 0, 30));
        run = 1'b1;
        repeat (3) cyc();
        check_eq("resume_no_early", 32'(sec_tick), 32'd0);
        cyc();
        check_eq("resume_tick", 32'(sec_tick), 32'd1);
        check_eq("resume_dout", 32'(dout), t24(0, 0, 31));

        // Increment wins over a coinciding tick
        set_time(0, 0, 5);
        repeat (3) cyc();
        inc_m = 1'b1;
        cyc();
        inc_m = 1'b0;
        check_eq("inc_vs_tick_dout", 32'(dout), t24(0, 1, 5));
        check_eq("inc_vs_tick_pulse", 32'(sec_tick), 32'd0);

        // Asynchronous reset mid-count clears outputs and disarms alarm
        set_h = 5'd25; set_en = 1'b1;
        cyc();
        set_en = 1'b0;
        check_eq("pre_rst_err", 32'(set_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout", 32'(dout), 32'd0);
        check_eq("async_rst_pulses", {28'd0, sec_tick, day_wrap, set_err, alarm_hit}, 32'd0);
        check_eq("async_rst_h12", 32'(hour12), 32'd12);
        check_eq("async_rst_pm", 32'(pm), 32'd0);
        cyc();
        rst_n = 1'b1;
        set_time(7, 29, 59);
        hit_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (alarm_hit) hit_cnt++;
        end
        check_eq("rst_alarm_disarmed", 32'(hit_cnt), 32'd0);
        check_eq("rst_after_run", 32'(dout), t24(7, 30, 0));

        // 12 h modulus
        run12 = 1'b1;
        set_h12 = 4'd12; set_m12 = 6'd0; set_s12 = 6'd0; set_en12 = 1'b1;
        cyc();
        check_eq("h12_bad_hour", 32'(set_err12), 32'd1);
        set_h12 = 4'd11; set_m12 = 6'd59; set_s12 = 6'd59;
        cyc();
        set_en12 = 1'b0;
        check_eq("h12_load", 32'(dout12), 32'({4'd11, 6'd59, 6'd59}));
        repeat (4) cyc();
        check_eq("h12_wrap_dout", 32'(dout12), 32'd0);
        check_eq("h12_day_wrap", 32'(day_wrap12), 32'd1);
        check_eq("h12_sec_tick", 32'(sec_tick12), 32'd1);
        check_eq("h12_hour12", 32'(hour12_12), 32'd0);
        check_eq("h12_pm", 32'(pm12), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
